// File: rtl/cache_fill_ctrl.sv
// Purpose: L1 miss handler; fetches an 8-word block from main memory into the I- or D-cache that missed (D first).
// Latency: miss seen in IDLE at cycle 0 -> requests cycles 1..8, returns 5..12, tag write cycle 12, release cycle 13.
// Backpressure: none on memory (fixed-latency, in-order returns); requesting stages are stalled via i_busy/d_busy.
module cache_fill_ctrl #(
    parameter int BLK_WORDS = 8,
    parameter int ADDR_W    = 16,
    localparam int OFF_W    = $clog2(BLK_WORDS),
    localparam int CNT_W    = OFF_W + 1,
    localparam int BLK_W    = ADDR_W - OFF_W - 1,
    localparam int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              i_busy,
    output logic              d_busy,
    output logic [DATA_W-1:0] fill_data,
    output logic [OFF_W-1:0]  fill_word,
    output logic [BLK_W-1:0]  fill_blk,
    output logic              i_data_we,
    output logic              d_data_we,
    output logic              i_tag_we,
    output logic              d_tag_we
);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_owner;        // 0 = I-cache, 1 = D-cache
    logic [BLK_W-1:0]   r_blk_addr;
    logic [CNT_W-1:0]   r_req_cnt;
    logic [CNT_W-1:0]   r_rcv_cnt;

    logic               w_start;        // latch a new miss this cycle
    logic               w_start_d;      // the latched miss belongs to the D-cache
    logic               w_rd_en;
    logic               w_ret;          // accepted return word
    logic               w_last;         // final word of the block
    logic               w_fill;

    // Byte-offset bits of the miss addresses do not matter for a block fill.
    logic               w_unused;
    assign w_unused = ^{i_miss_addr[OFF_W:0], d_miss_addr[OFF_W:0]};

    assign w_fill = (r_state == S_FILL);

    // State register; reset abandons any fill in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode; D-side miss wins when both are pending.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_start_d    = 1'b0;
        w_rd_en      = 1'b0;
        w_ret        = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (d_miss) begin
                    w_start      = 1'b1;
                    w_start_d    = 1'b1;
                    w_next_state = S_FILL;
                end else if (i_miss) begin
                    w_start      = 1'b1;
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                w_rd_en = (r_req_cnt < CNT_W'(BLK_WORDS));
                w_ret   = mem_valid && (r_rcv_cnt < CNT_W'(BLK_WORDS));
                w_last  = w_ret && (r_rcv_cnt == CNT_W'(BLK_WORDS - 1));
                if (w_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Latch owner and block address at fill start; step request/return counters during the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= 1'b0;
            r_blk_addr <= '0;
            r_req_cnt  <= '0;
            r_rcv_cnt  <= '0;
        end else if (w_start) begin
            r_owner    <= w_start_d;
            r_blk_addr <= w_start_d ? d_miss_addr[ADDR_W-1:OFF_W+1]
                                    : i_miss_addr[ADDR_W-1:OFF_W+1];
            r_req_cnt  <= '0;
            r_rcv_cnt  <= '0;
        end else begin
            if (w_rd_en) begin
                r_req_cnt <= r_req_cnt + CNT_W'(1);
            end
            if (w_ret) begin
                r_rcv_cnt <= r_rcv_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_rd_en = w_rd_en;
    assign mem_addr  = {r_blk_addr, r_req_cnt[OFF_W-1:0], 1'b0};

    assign fill_data = mem_data;
    assign fill_word = r_rcv_cnt[OFF_W-1:0];
    assign fill_blk  = r_blk_addr;

    assign i_data_we = w_ret  & ~r_owner;
    assign d_data_we = w_ret  &  r_owner;
    assign i_tag_we  = w_last & ~r_owner;
    assign d_tag_we  = w_last &  r_owner;

    // Stall is combinational so the pipeline freezes in the miss cycle itself.
    assign i_busy = i_miss | (w_fill & ~r_owner);
    assign d_busy = d_miss | (w_fill &  r_owner);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Purpose: directed self-checking bench for cache_fill_ctrl with a fixed 4-cycle in-order memory model.
// Latency: checks are made per cycle against hand-derived timelines relative to the miss cycle.
// Backpressure: not applicable; memory always accepts requests.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss;
    logic [15:0] i_miss_addr, d_miss_addr;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        i_busy, d_busy;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic [11:0] fill_blk;
    logic        i_data_we, d_data_we, i_tag_we, d_tag_we;

    int n_chk = 0;
    int n_err = 0;

    cache_fill_ctrl #(.BLK_WORDS(8), .ADDR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_miss      (i_miss),
        .i_miss_addr (i_miss_addr),
        .d_miss      (d_miss),
        .d_miss_addr (d_miss_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .i_busy      (i_busy),
        .d_busy      (d_busy),
        .fill_data   (fill_data),
        .fill_word   (fill_word),
        .fill_blk    (fill_blk),
        .i_data_we   (i_data_we),
        .d_data_we   (d_data_we),
        .i_tag_we    (i_tag_we),
        .d_tag_we    (d_tag_we)
    );

    always #5 clk = ~clk;

    // Memory model: request seen in cycle n is returned in cycle n+4 with data 0xA000 + word offset.
    logic        m_req  = 1'b0;
    logic [15:0] m_addr = 16'h0;
    logic [3:0]  m_pv   = 4'h0;
    logic [15:0] m_pd [4];
    logic        stray  = 1'b0;

    // Capture this cycle's request after inputs and outputs have settled.
    always @(negedge clk) begin
        #3;
        m_req  = mem_rd_en;
        m_addr = mem_addr;
    end

    // Advance the return pipeline just after each rising edge.
    always @(posedge clk) begin
        #1;
        m_pv    = {m_pv[2:0], m_req};
        m_pd[3] = m_pd[2];
        m_pd[2] = m_pd[1];
        m_pd[1] = m_pd[0];
        m_pd[0] = 16'hA000 + {13'd0, m_addr[3:1]};
        mem_valid = m_pv[3] | stray;
        mem_data  = m_pv[3] ? m_pd[3] : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected outputs for relative cycle r of a fill owned by is_d with block base address base.
    task automatic chk_fill(input string nm, input int r, input logic is_d, input logic [15:0] base);
        logic exp_rd, exp_we, exp_tag;
        exp_rd  = (r >= 1) && (r <= 8);
        exp_we  = (r >= 5) && (r <= 12);
        exp_tag = (r == 12);
        chk($sformatf("%s r%0d rd_en", nm, r), {31'd0, mem_rd_en}, {31'd0, exp_rd});
        if (exp_rd)
            chk($sformatf("%s r%0d addr", nm, r), {16'd0, mem_addr}, 32'(base) + 32'(2 * (r - 1)));
        chk($sformatf("%s r%0d own_we", nm, r), {31'd0, is_d ? d_data_we : i_data_we}, {31'd0, exp_we});
        chk($sformatf("%s r%0d oth_we", nm, r), {31'd0, is_d ? i_data_we : d_data_we}, 32'd0);
        if (exp_we) begin
            chk($sformatf("%s r%0d word", nm, r), {29'd0, fill_word}, 32'(r - 5));
            chk($sformatf("%s r%0d data", nm, r), {16'd0, fill_data}, 32'hA000 + 32'(r - 5));
        end
        chk($sformatf("%s r%0d own_tag", nm, r), {31'd0, is_d ? d_tag_we : i_tag_we}, {31'd0, exp_tag});
        chk($sformatf("%s r%0d oth_tag", nm, r), {31'd0, is_d ? i_tag_we : d_tag_we}, 32'd0);
        if (exp_tag)
            chk($sformatf("%s r%0d blk", nm, r), {20'd0, fill_blk}, {20'd0, base[15:4]});
    endtask

    // Nothing in flight: no requests, no strobes, counters and block address as given.
    task automatic chk_quiet(input string nm, input logic [15:0] exp_addr);
        chk({nm, " rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({nm, " addr"},  {16'd0, mem_addr},  {16'd0, exp_addr});
        chk({nm, " word"},  {29'd0, fill_word}, 32'd0);
        chk({nm, " we"},    {30'd0, i_data_we, d_data_we}, 32'd0);
        chk({nm, " tag"},   {30'd0, i_tag_we, d_tag_we},   32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_miss = 1'b0; d_miss = 1'b0;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0;
        mem_valid = 1'b0; mem_data = 16'h0;
        m_pd[0] = 16'h0; m_pd[1] = 16'h0; m_pd[2] = 16'h0; m_pd[3] = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("rst", 16'h0000);
        chk("rst busy", {30'd0, i_busy, d_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a D fill
        d_miss = 1'b1; d_miss_addr = 16'h4560;
        repeat (3) @(negedge clk);
        chk("rmf c3 rd_en pre", {31'd0, mem_rd_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_quiet("rmf c3", 16'h0000);
        chk("rmf c3 d_busy miss", {31'd0, d_busy}, 32'd1);
        d_miss = 1'b0;
        #1;
        chk("rmf c3 d_busy", {31'd0, d_busy}, 32'd0);
        for (int c = 4; c <= 12; c++) begin
            @(negedge clk);
            if (c == 4) rst_n = 1'b1;
            stray = (c >= 6) && (c <= 8);
            #1;
            chk_quiet($sformatf("rmf c%0d", c), 16'h0000);
            chk($sformatf("rmf c%0d busy", c), {30'd0, i_busy, d_busy}, 32'd0);
        end
        stray = 1'b0;
        repeat (3) @(negedge clk);

        // D miss
        d_miss = 1'b1; d_miss_addr = 16'h1236;
        #1;
        chk("dm c0 d_busy", {31'd0, d_busy}, 32'd1);
        chk("dm c0 i_busy", {31'd0, i_busy}, 32'd0);
        chk_fill("dm", 0, 1'b1, 16'h1230);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            #1;
            chk_fill("dm", c, 1'b1, 16'h1230);
            chk($sformatf("dm c%0d d_busy", c), {31'd0, d_busy}, {31'd0, c <= 12});
            chk($sformatf("dm c%0d i_busy", c), {31'd0, i_busy}, 32'd0);
            if (c == 12) d_miss = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Simultaneous misses: D first, then I starting cycle 13
        i_miss = 1'b1; i_miss_addr = 16'h0040;
        d_miss = 1'b1; d_miss_addr = 16'h8000;
        #1;
        chk_fill("sd", 0, 1'b1, 16'h8000);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            #1;
            if (c <= 12) chk_fill("sd", c, 1'b1, 16'h8000);
            else         chk_fill("si", c - 13, 1'b0, 16'h0040);
            chk($sformatf("sim c%0d i_busy", c), {31'd0, i_busy}, {31'd0, c <= 25});
            chk($sformatf("sim c%0d d_busy", c), {31'd0, d_busy}, {31'd0, c <= 12});
            if (c == 12) d_miss = 1'b0;
            if (c == 25) i_miss = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Top-of-memory block
        i_miss = 1'b1; i_miss_addr = 16'hFFFE;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            #1;
            chk_fill("wr", c, 1'b0, 16'hFFF0);
            if (c == 12) i_miss = 1'b0;
        end

        // Stray returns in IDLE after a completed fill
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            stray = (c < 3);
            #1;
            chk_quiet($sformatf("stray c%0d", c), 16'hFFF0);
        end
        stray = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Multi-cycle miss handler between the pipeline's L1 caches and the shared main memory. When the fetch stage or the memory stage misses, it latches the missing block address and issues eight sequential word reads. It steers each returning word into the data array of the cache that missed, then writes that cache's tag/valid entry. It stalls the requesting cache's pipeline stage until the fill completes. The D-cache has priority over the I-cache.

## Interface
Parameters:
- BLK_WORDS, 8, words per cache block (16-bit words; 16-byte block).
- ADDR_W, 16, byte-address width.

Ports (clock and reset first):
- clk  in  1  system clock; every flop updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_miss  in  1  I-cache lookup missed; level signal, held until i_tag_we.
- i_miss_addr  in  16  byte address of the I-side miss.
- d_miss  in  1  D-cache lookup missed; level signal, held until d_tag_we.
- d_miss_addr  in  16  byte address of the D-side miss.
- mem_rd_en  out  1  read request to main memory, one word per cycle.
- mem_addr  out  16  read address, {blk_addr, req_cnt[2:0], 1'b0}.
- mem_valid  in  1  main memory returns a word; fixed 4-cycle latency, in request order.
- mem_data  in  16  returned word.
- i_busy  out  1  stall for the fetch stage.
- d_busy  out  1  stall for the memory stage.
- fill_data  out  16  equals mem_data.
- fill_word  out  3  word offset being written, equals rcv_cnt.
- fill_blk  out  12  latched block address, addr[15:4]; used for the tag write.
- i_data_we, d_data_we  out  1 each  data-array write strobes.
- i_tag_we, d_tag_we  out  1 each  one-cycle tag/valid write strobes.

## Operation
- States:
  - IDLE.
  - FILL.
  - A 1-bit owner flop: 0 = I, 1 = D.
- Counters:
  - req_cnt, 4 bits, 0..8.
  - rcv_cnt, 4 bits, 0..8.
- IDLE:
  - If d_miss=1: latch blk_addr = d_miss_addr[15:4], set owner=D, go to FILL.
  - Else if i_miss=1: latch i_miss_addr[15:4], set owner=I, go to FILL.
  - On entry to FILL, both counters are cleared.
- FILL, request side:
  - mem_rd_en = (req_cnt<8).
  - req_cnt increments on each issued request and saturates at 8.
- FILL, return side:
  - On each mem_valid, the owner's data_we = 1 and rcv_cnt increments.
  - On the 8th mem_valid (rcv_cnt==7 && mem_valid), the owner's tag_we = 1 in the same cycle, and the next state is IDLE.
- Busy outputs:
  - d_busy = d_miss | (FILL & owner==D).
  - i_busy = i_miss | (FILL & owner==I).
  - Both are combinational, so the stall is asserted in the miss cycle itself.
- Simultaneous i_miss and d_miss: D is served first; the I side stays busy and is served in the next IDLE cycle.
- A miss arriving during FILL for the non-owner cache is not latched; that cache stays busy via its own miss level.
- mem_valid while in IDLE is ignored: no write strobes, no counter change.
- mem_valid in FILL after rcv_cnt reaches 8 cannot occur; if it does, it is ignored.
- fill_blk and owner are held constant for the whole FILL.
- Changes to the miss_addr inputs during FILL have no effect.
- All write strobes are combinational from state, owner and mem_valid. fill_data and fill_word are combinational.

## Timing
- Reset (rst_n=0, any time, including mid-fill):
  - state=IDLE, owner=I, req_cnt=rcv_cnt=0, blk_addr=0.
  - All strobes and mem_rd_en are 0; mem_addr=0x0000.
  - Busy outputs follow the miss inputs only.
  - In-flight memory returns after reset are ignored.
- Miss sampled in IDLE at cycle 0 gives this timeline:
  - Requests in cycles 1..8.
  - Returns in cycles 5..12.
  - tag_we in cycle 12.
  - IDLE in cycle 13, busy low in cycle 13 (the miss input drops on the hit).
- Miss-to-release latency: 13 cycles.
- Back-to-back fills: a second pending miss is latched in cycle 13, so its requests start in cycle 14.

## Test plan
- Reset mid-fill:
  - Stimulus: pull rst_n low at cycle 3 of a D fill; release; pulse mem_valid 3 times.
  - Required: state IDLE, no we strobes, mem_rd_en=0 until a new miss.
- D miss:
  - Stimulus: d_miss_addr=0x1236; memory returns 0xA000+k for word k.
  - Required:
    - mem_addr 0x1230, 0x1232 .. 0x123E in cycles 1..8.
    - d_data_we with fill_word 0..7 and data 0xA000..0xA007 in cycles 5..12.
    - d_tag_we in cycle 12 with fill_blk=0x123.
    - d_busy low in cycle 13.
    - i_* strobes stay 0 throughout.
- Simultaneous misses:
  - Stimulus: i_miss and d_miss both high, i_miss_addr=0x0040, d_miss_addr=0x8000.
  - Required:
    - D fill (addresses 0x8000..0x800E) first, i_busy held high throughout.
    - I fill starts in cycle 13 (requests 0x0040..0x004E from cycle 14).
    - i_tag_we in cycle 25.
- Stray returns:
  - Stimulus: mem_valid pulses in IDLE.
  - Required: all strobes stay 0, counters stay 0.
- Top-of-memory wrap:
  - Stimulus: i_miss_addr=0xFFFE.
  - Required: requests 0xFFF0..0xFFFE with no wrap to 0x0000; fill_blk=0xFFF.
